// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared encodings for the lane-FIFO round-robin scheduler.
// State is one-hot, so any other pattern is treated as corrupt.
package fifo_rr_scheduler_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 4;
  localparam int CNT_W_DEF     = 3;

  localparam logic LANE_0 = 1'b0;
  localparam logic LANE_1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_SERVE_0 = 3'b010,
    ST_SERVE_1 = 3'b100
  } state_e;

  function automatic state_e serve_state(input logic lane);
    return (lane == LANE_1) ? ST_SERVE_1 : ST_SERVE_0;
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// Bundle between the two lane FIFOs, the scheduler and the downstream FIFO.
// master = scheduler side, slave = FIFO/environment side.
interface fifo_rr_scheduler_if
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  // Handshake: pop_x is a read strobe with no ready; it is only raised when
  // empty_x==0 and almost_full==0, and data_x is valid the cycle after pop_x.
  // push_out is a write strobe; almost_full leaves room for one in-flight word.
  logic              empty_0;
  logic              empty_1;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic              almost_full;
  logic              pop_0;
  logic              pop_1;
  logic              push_out;
  logic [DATA_W-1:0] data_out;
  logic              lane_out;
  logic              idle;

  modport master (
    input  empty_0, empty_1, data_0, data_1, almost_full,
    output pop_0, pop_1, push_out, data_out, lane_out, idle
  );

  modport slave (
    output empty_0, empty_1, data_0, data_1, almost_full,
    input  pop_0, pop_1, push_out, data_out, lane_out, idle
  );

endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin pop scheduler for two lane FIFOs with bounded bursts and
// downstream backpressure; forwards popped words tagged with their lane.
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                clk_8f,
  input  logic                reset,
  fifo_rr_scheduler_if.master bus,
  output logic [2:0]          dbg_state_o,
  output logic [CNT_W-1:0]    dbg_burst_cnt_o,
  output logic                dbg_last_lane_o
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              last_lane_q, last_lane_d;
  logic              push_q;
  logic              lane_q;

  logic              do_pop;
  logic              pop_lane;
  logic              cont_burst;
  logic              cur_lane;
  logic              own_empty;
  logic              oth_empty;
  logic              pop_0;
  logic              pop_1;
  logic [DATA_W-1:0] sel_data;

  assign cur_lane  = (state_q == ST_SERVE_1) ? LANE_1 : LANE_0;
  assign own_empty = (cur_lane == LANE_1) ? bus.empty_1 : bus.empty_0;
  assign oth_empty = (cur_lane == LANE_1) ? bus.empty_0 : bus.empty_1;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_lane_d = last_lane_q;
    do_pop      = 1'b0;
    pop_lane    = LANE_0;
    cont_burst  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.almost_full) begin
          if (!bus.empty_0 && !bus.empty_1) begin
            do_pop   = 1'b1;
            pop_lane = ~last_lane_q;
          end else if (!bus.empty_0) begin
            do_pop   = 1'b1;
            pop_lane = LANE_0;
          end else if (!bus.empty_1) begin
            do_pop   = 1'b1;
            pop_lane = LANE_1;
          end
        end
      end
      ST_SERVE_0, ST_SERVE_1: begin
        // Backpressure freezes the burst: counter and last lane are held.
        if (!bus.almost_full) begin
          if (!own_empty && ((burst_cnt_q < BURST_MAX) || oth_empty)) begin
            do_pop     = 1'b1;
            pop_lane   = cur_lane;
            cont_burst = 1'b1;
          end else if (!oth_empty) begin
            do_pop   = 1'b1;
            pop_lane = ~cur_lane;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_pop) begin
      state_d     = serve_state(pop_lane);
      last_lane_d = pop_lane;
      if (!cont_burst) begin
        burst_cnt_d = CNT_W'(1);
      end else if (burst_cnt_q < BURST_MAX) begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pop_0 = reset && do_pop && (pop_lane == LANE_0);
  assign pop_1 = reset && do_pop && (pop_lane == LANE_1);

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      last_lane_q <= LANE_1;
      push_q      <= 1'b0;
      lane_q      <= LANE_0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_lane_q <= last_lane_d;
      push_q      <= pop_0 | pop_1;
      lane_q      <= pop_1;
    end
  end

  // The lane FIFOs present read data one cycle after the pop, which lines up
  // with the registered push, so the word is steered through without a flop.
  assign sel_data = (lane_q == LANE_1) ? bus.data_1 : bus.data_0;

  assign bus.pop_0    = pop_0;
  assign bus.pop_1    = pop_1;
  assign bus.push_out = push_q;
  assign bus.lane_out = lane_q;
  assign bus.data_out = push_q ? sel_data : '0;
  assign bus.idle     = (state_q == ST_IDLE) && !push_q;

  assign dbg_state_o     = state_q;
  assign dbg_burst_cnt_o = burst_cnt_q;
  assign dbg_last_lane_o = last_lane_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: cycle vector table plus lane-FIFO driven
// streaming sequences checked against a hand-built expected queue.
module tb_fifo_rr_scheduler;
  import fifo_rr_scheduler_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_8f = 1'b0;
  logic reset;
  always #5 clk_8f = ~clk_8f;

  fifo_rr_scheduler_if #(.DATA_W(8)) bus ();

  logic [2:0] dbg_state;
  logic [2:0] dbg_cnt;
  logic       dbg_last;

  fifo_rr_scheduler #(.DATA_W(8), .BURST_LEN(4), .CNT_W(3)) dut (
    .clk_8f          (clk_8f),
    .reset           (reset),
    .bus             (bus),
    .dbg_state_o     (dbg_state),
    .dbg_burst_cnt_o (dbg_cnt),
    .dbg_last_lane_o (dbg_last)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] exp_q[$];
  logic [1:0] pop_hist[0:63];
  logic       push_hist[0:63];

  typedef struct packed {
    logic       rst;
    logic       e0;
    logic       e1;
    logic       af;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       p0;
    logic       p1;
    logic       push;
    logic       lane;
    logic [7:0] dout;
    logic       idle;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add(input logic rst, input logic e0, input logic e1, input logic af,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic p0, input logic p1, input logic push, input logic lane,
                     input logic [7:0] dout, input logic idle);
    vecs.push_back({rst, e0, e1, af, d0, d1, p0, p1, push, lane, dout, idle});
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus.empty_0     = 1'b1;
    bus.empty_1     = 1'b1;
    bus.almost_full = 1'b0;
    repeat (2) begin
      @(posedge clk_8f);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic fill(input logic lane, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      if (lane) q1.push_back(base + 8'(k));
      else      q0.push_back(base + 8'(k));
    end
  endtask

  task automatic push_exp(input logic lane, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({lane, base + 8'(k)});
  endtask

  // Lane FIFOs modelled as queues: read data appears the cycle after a pop.
  task automatic run_model(input int ncyc, input int af_lo, input int af_hi,
                           input int fill_c, input logic [7:0] fill_base, input int fill_n);
    logic p0, p1;
    for (int i = 0; i < 64; i++) begin
      pop_hist[i]  = 2'b00;
      push_hist[i] = 1'b0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      bus.almost_full = (c >= af_lo) && (c <= af_hi);
      if (c == fill_c) fill(1'b0, fill_base, fill_n);
      bus.empty_0 = (q0.size() == 0);
      bus.empty_1 = (q1.size() == 0);
      @(negedge clk_8f);
      p0           = bus.pop_0;
      p1           = bus.pop_1;
      pop_hist[c]  = {p1, p0};
      push_hist[c] = bus.push_out;
      check($sformatf("pop_rules c%0d", c),
            32'((p0 && p1) || (bus.almost_full && (p0 || p1)) ||
                (p0 && bus.empty_0) || (p1 && bus.empty_1)), 32'd0);
      if (bus.push_out) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra c%0d got lane=%0d data=%0h required no push",
                   c, bus.lane_out, bus.data_out);
        end else begin
          check($sformatf("sb_word c%0d", c), 32'({bus.lane_out, bus.data_out}),
                32'(exp_q.pop_front()));
        end
      end
      @(posedge clk_8f);
      #1;
      bus.data_0 = 8'hEE;
      bus.data_1 = 8'hEE;
      if (p0 && q0.size() > 0) bus.data_0 = q0.pop_front();
      if (p1 && q1.size() > 0) bus.data_1 = q1.pop_front();
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int n;

    //  rst e0 e1 af  d0     d1     | p0 p1 pu ln dout   idle
    for (int i = 0; i < 4; i++)
      add(1, 0, 0, 0, 8'hAA, 8'hBB,   0, 0, 0, 0, 8'h00, 1);
    vecs[0].rst = 0; vecs[1].rst = 0; vecs[2].rst = 0; vecs[3].rst = 0;
    add(1, 0, 0, 0, 8'hAA, 8'hBB,   1, 0, 0, 0, 8'h00, 1);
    add(1, 0, 0, 0, 8'h10, 8'hBB,   1, 0, 1, 0, 8'h10, 0);
    add(1, 0, 0, 0, 8'h11, 8'hBB,   1, 0, 1, 0, 8'h11, 0);
    add(1, 0, 0, 0, 8'h12, 8'hBB,   1, 0, 1, 0, 8'h12, 0);
    add(1, 0, 0, 0, 8'h13, 8'hBB,   0, 1, 1, 0, 8'h13, 0);
    add(1, 0, 0, 0, 8'hAA, 8'h20,   0, 1, 1, 1, 8'h20, 0);
    add(1, 0, 0, 1, 8'hAA, 8'h21,   0, 0, 1, 1, 8'h21, 0);
    add(1, 0, 0, 1, 8'hAA, 8'h55,   0, 0, 0, 0, 8'h00, 0);
    add(1, 1, 1, 0, 8'hAA, 8'hBB,   0, 0, 0, 0, 8'h00, 0);
    add(1, 1, 1, 0, 8'hAA, 8'hBB,   0, 0, 0, 0, 8'h00, 1);
    add(1, 1, 0, 0, 8'hAA, 8'hBB,   0, 1, 0, 0, 8'h00, 1);
    add(1, 0, 0, 0, 8'hAA, 8'h31,   0, 1, 1, 1, 8'h31, 0);
    add(1, 0, 0, 0, 8'hAA, 8'h32,   0, 1, 1, 1, 8'h32, 0);
    add(1, 1, 0, 0, 8'hAA, 8'h33,   0, 1, 1, 1, 8'h33, 0);
    add(1, 1, 0, 0, 8'hAA, 8'h34,   0, 1, 1, 1, 8'h34, 0);
    add(1, 0, 0, 0, 8'hAA, 8'h35,   1, 0, 1, 1, 8'h35, 0);
    add(1, 0, 1, 0, 8'h40, 8'hBB,   1, 0, 1, 0, 8'h40, 0);
    add(1, 1, 1, 0, 8'h41, 8'hBB,   0, 0, 1, 0, 8'h41, 0);
    add(1, 0, 0, 0, 8'hAA, 8'hBB,   0, 1, 0, 0, 8'h00, 1);
    add(1, 1, 1, 0, 8'hAA, 8'h66,   0, 0, 1, 1, 8'h66, 0);
    add(1, 1, 1, 0, 8'hAA, 8'hBB,   0, 0, 0, 0, 8'h00, 1);
    add(1, 0, 1, 0, 8'hAA, 8'hBB,   1, 0, 0, 0, 8'h00, 1);
    add(0, 0, 1, 0, 8'h5A, 8'hBB,   0, 0, 1, 0, 8'h5A, 0);
    add(0, 0, 1, 0, 8'hAA, 8'hBB,   0, 0, 0, 0, 8'h00, 1);
    add(1, 0, 0, 0, 8'hAA, 8'hBB,   1, 0, 0, 0, 8'h00, 1);
    add(1, 1, 1, 0, 8'h77, 8'hBB,   0, 0, 1, 0, 8'h77, 0);
    add(1, 1, 1, 0, 8'hAA, 8'hBB,   0, 0, 0, 0, 8'h00, 1);

    reset           = 1'b0;
    bus.empty_0     = 1'b1;
    bus.empty_1     = 1'b1;
    bus.almost_full = 1'b0;
    bus.data_0      = 8'h00;
    bus.data_1      = 8'h00;
    @(posedge clk_8f);
    #1;
    @(negedge clk_8f);
    check("rst_regs", 32'({dbg_state, dbg_cnt, dbg_last, bus.push_out, bus.lane_out}),
          32'({3'b001, 3'b000, 1'b1, 1'b0, 1'b0}));
    @(posedge clk_8f);
    #1;

    // Cycle-by-cycle vectors; lane_out only matters while push_out is high.
    for (int i = 0; i < vecs.size(); i++) begin
      reset           = vecs[i].rst;
      bus.empty_0     = vecs[i].e0;
      bus.empty_1     = vecs[i].e1;
      bus.almost_full = vecs[i].af;
      bus.data_0      = vecs[i].d0;
      bus.data_1      = vecs[i].d1;
      @(negedge clk_8f);
      check($sformatf("vec%0d", i),
            32'({bus.pop_0, bus.pop_1, bus.push_out, vecs[i].push ? bus.lane_out : 1'b0,
                 bus.data_out, bus.idle}),
            32'({vecs[i].p0, vecs[i].p1, vecs[i].push, vecs[i].lane,
                 vecs[i].dout, vecs[i].idle}));
      @(posedge clk_8f);
      #1;
    end

    // Two full lanes: bursts of 4 alternate with no idle gaps.
    do_reset();
    fill(1'b0, 8'h00, 10);
    fill(1'b1, 8'h80, 10);
    push_exp(1'b0, 8'h00, 4); push_exp(1'b1, 8'h80, 4);
    push_exp(1'b0, 8'h04, 4); push_exp(1'b1, 8'h84, 4);
    push_exp(1'b0, 8'h08, 2); push_exp(1'b1, 8'h88, 2);
    run_model(24, 0, -1, 0, 8'h00, 0);
    n = 0;
    for (int c = 2; c <= 21; c++) n += int'(push_hist[c]);
    check("burst_nogap", 32'(n), 32'd20);
    check("burst_drain", 32'(exp_q.size()), 32'd0);

    // almost_full for cycles 3..5 in the middle of a lane-0 burst.
    fill(1'b0, 8'h10, 8);
    fill(1'b1, 8'h90, 8);
    push_exp(1'b0, 8'h10, 4); push_exp(1'b1, 8'h90, 4);
    push_exp(1'b0, 8'h14, 4); push_exp(1'b1, 8'h94, 4);
    run_model(24, 3, 5, 0, 8'h00, 0);
    check("af_inflight", 32'(push_hist[3]), 32'd1);
    check("af_hold", 32'({push_hist[4], push_hist[5], push_hist[6],
                          pop_hist[3], pop_hist[4], pop_hist[5]}), 32'd0);
    check("af_resume", 32'(pop_hist[6]), 32'b01);
    check("af_switch", 32'({pop_hist[7], pop_hist[8]}), 32'b0110);
    check("af_drain", 32'(exp_q.size()), 32'd0);

    // Lane 1 alone for 6 words, lane 0 appears right after the 6th pop.
    fill(1'b1, 8'hA0, 6);
    push_exp(1'b1, 8'hA0, 6);
    push_exp(1'b0, 8'hC0, 2);
    run_model(12, 0, -1, 7, 8'hC0, 2);
    check("l1_sat_pop", 32'(pop_hist[6]), 32'b10);
    check("l0_first", 32'(pop_hist[7]), 32'b01);
    check("l1l0_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
